// File: rtl/svn_scan_capture.sv
// svn_scan_capture: receive side of a multiplexed seven-segment display bus.
// Qualifies each anode slot over STABLE_CYCLES identical samples, decodes the
// active-low segment pattern back to hex and tracks frame completion and errors.
module svn_scan_capture #(
   parameter int unsigned STABLE_CYCLES = 1,
   parameter int unsigned N_DIGITS      = 8
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic [6:0]            seg,
   input  logic                  dp,
   input  logic [N_DIGITS-1:0]   an,
   output logic [4*N_DIGITS-1:0] digits,
   output logic [N_DIGITS-1:0]   dig_valid,
   output logic [N_DIGITS-1:0]   dp_out,
   output logic                  frame_done,
   output logic                  err,
   output logic [7:0]            err_cnt
);

   localparam int unsigned IdxW      = $clog2(N_DIGITS);
   localparam int unsigned SmpW      = N_DIGITS + 8;
   localparam logic [7:0]  StableCnt = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {StIdle, StTrack, StHeld} state_e;

   // Returns {legal, value}; segments ordered CA..CG, active-low.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b0000001: r = 5'h10;
         7'b1001111: r = 5'h11;
         7'b0010010: r = 5'h12;
         7'b0000110: r = 5'h13;
         7'b1001100: r = 5'h14;
         7'b0100100: r = 5'h15;
         7'b0100000: r = 5'h16;
         7'b0001111: r = 5'h17;
         7'b0000000: r = 5'h18;
         7'b0000100: r = 5'h19;
         7'b0001000: r = 5'h1A;
         7'b1100000: r = 5'h1B;
         7'b0110001: r = 5'h1C;
         7'b1000010: r = 5'h1D;
         7'b0110000: r = 5'h1E;
         7'b0111000: r = 5'h1F;
         default:    r = 5'h00;
      endcase
      return r;
   endfunction

   logic [6:0]            seg_q;
   logic                  dp_q;
   logic [N_DIGITS-1:0]   an_q;
   state_e                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [SmpW-1:0]       prev_q, prev_d;
   logic [N_DIGITS-1:0]   seen_q, seen_d;
   logic [4*N_DIGITS-1:0] digits_q, digits_d;
   logic [N_DIGITS-1:0]   dig_valid_q, dig_valid_d;
   logic [N_DIGITS-1:0]   dp_out_q, dp_out_d;
   logic                  frame_done_q, frame_done_d;
   logic                  err_q, err_d;
   logic [7:0]            err_cnt_q, err_cnt_d;

   logic [N_DIGITS-1:0]   an_low;
   logic [SmpW-1:0]       sample;
   logic                  is_none, is_one, is_multi, same;
   logic                  latch, err_event;
   logic [IdxW-1:0]       idx;
   logic [4:0]            dec;

   // Classify the registered anode sample and decode the registered segments.
   always_comb begin
      an_low   = ~an_q;
      is_none  = (an_low == '0);
      is_one   = !is_none && ((an_low & (an_low - {{(N_DIGITS-1){1'b0}}, 1'b1})) == '0);
      is_multi = !is_none && !is_one;
      idx      = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (an_low[i]) idx = IdxW'(i);
      end
      sample = {an_q, seg_q, dp_q};
      same   = (sample == prev_q);
      dec    = seg_decode(seg_q);
   end

   // Slot qualification FSM, latch of decoded slots, frame and error bookkeeping.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      prev_d       = sample;
      seen_d       = seen_q;
      digits_d     = digits_q;
      dig_valid_d  = dig_valid_q;
      dp_out_d     = dp_out_q;
      frame_done_d = 1'b0;
      err_d        = err_q;
      err_cnt_d    = err_cnt_q;
      latch        = 1'b0;
      err_event    = 1'b0;

      if (is_multi) begin
         // Bus contention wins over any pending latch.
         err_event = 1'b1;
         state_d   = StIdle;
         cnt_d     = '0;
      end else if (is_none) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (state_q == StTrack && same) begin
         cnt_d = cnt_q + 8'd1;
         if (cnt_d == StableCnt) begin
            latch   = 1'b1;
            state_d = StHeld;
         end
      end else if (!(state_q == StHeld && same)) begin
         // New slot (from idle, or a changed sample while tracking/held).
         cnt_d = 8'd1;
         if (StableCnt == 8'd1) begin
            latch   = 1'b1;
            state_d = StHeld;
         end else begin
            state_d = StTrack;
         end
      end

      if (latch) begin
         if (dec[4]) begin
            digits_d[{idx, 2'b00} +: 4] = dec[3:0];
            dig_valid_d[idx]            = 1'b1;
         end else begin
            dig_valid_d[idx] = 1'b0;
            err_event        = 1'b1;
         end
         dp_out_d[idx] = ~dp_q;
         seen_d[idx]   = 1'b1;
      end

      if (seen_d == '1) begin
         frame_done_d = 1'b1;
         seen_d       = '0;
      end

      if (err_event) begin
         err_d = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Input sample register; idles as a blank, deselected bus.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         seg_q <= '1;
         dp_q  <= 1'b1;
         an_q  <= '1;
      end else begin
         seg_q <= seg;
         dp_q  <= dp;
         an_q  <= an;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         prev_q       <= '1;
         seen_q       <= '0;
         digits_q     <= '0;
         dig_valid_q  <= '0;
         dp_out_q     <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         prev_q       <= prev_d;
         seen_q       <= seen_d;
         digits_q     <= digits_d;
         dig_valid_q  <= dig_valid_d;
         dp_out_q     <= dp_out_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign digits     = digits_q;
   assign dig_valid  = dig_valid_q;
   assign dp_out     = dp_out_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_svn_scan_capture.sv
// Bench for svn_scan_capture: two instances (STABLE_CYCLES 1 and 3) share one bus and
// are compared every cycle against a run-length reference model of the capture rules.
module tb_svn_scan_capture;

   logic        clk;
   logic        sys_rst_n;
   logic [6:0]  seg;
   logic        dp;
   logic [7:0]  an;

   logic [31:0] d1_digits, d3_digits;
   logic [7:0]  d1_dig_valid, d3_dig_valid;
   logic [7:0]  d1_dp_out, d3_dp_out;
   logic        d1_frame_done, d3_frame_done;
   logic        d1_err, d3_err;
   logic [7:0]  d1_err_cnt, d3_err_cnt;

   int n_vec;
   int n_err;
   int fd1;
   int fd3;

   // Segment patterns for hex 0..F, CA..CG, active-low.
   logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model state, index 0 = STABLE_CYCLES 1, index 1 = STABLE_CYCLES 3.
   logic [15:0] m_in;
   int          m_run    [2];
   logic [15:0] m_last   [2];
   logic [31:0] m_digits [2];
   logic [7:0]  m_valid  [2];
   logic [7:0]  m_dpo    [2];
   logic [7:0]  m_seen   [2];
   logic        m_done   [2];
   logic        m_err    [2];
   int          m_cnt    [2];

   svn_scan_capture #(.STABLE_CYCLES(1), .N_DIGITS(8)) u_dut1 (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .digits     (d1_digits),
      .dig_valid  (d1_dig_valid),
      .dp_out     (d1_dp_out),
      .frame_done (d1_frame_done),
      .err        (d1_err),
      .err_cnt    (d1_err_cnt)
   );

   svn_scan_capture #(.STABLE_CYCLES(3), .N_DIGITS(8)) u_dut3 (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .digits     (d3_digits),
      .dig_valid  (d3_dig_valid),
      .dp_out     (d3_dp_out),
      .frame_done (d3_frame_done),
      .err        (d3_err),
      .err_cnt    (d3_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic [31:0] d, input logic [7:0] v,
                                        input logic [7:0] p, input logic fd, input logic e,
                                        input logic [7:0] c);
      return {6'b0, d, v, p, fd, e, c};
   endfunction

   task automatic model_reset();
      m_in = 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
         m_run[k]    = 0;
         m_last[k]   = 16'hFFFF;
         m_digits[k] = '0;
         m_valid[k]  = '0;
         m_dpo[k]    = '0;
         m_seen[k]   = '0;
         m_done[k]   = 1'b0;
         m_err[k]    = 1'b0;
         m_cnt[k]    = 0;
      end
   endtask

   // A slot latches when a run of identical one-hot samples reaches exactly the
   // stability threshold; any other anode state breaks the run.
   task automatic model_step(input int k);
      logic [7:0] an_s;
      logic [6:0] seg_s;
      logic       dp_s;
      int         nlow, st, slot, val;
      logic       ev, lat;
      st    = (k == 0) ? 1 : 3;
      an_s  = m_in[15:8];
      seg_s = m_in[7:1];
      dp_s  = m_in[0];
      nlow  = $countones(~an_s);
      ev    = 1'b0;
      lat   = 1'b0;
      m_done[k] = 1'b0;
      if (nlow >= 2) begin
         ev       = 1'b1;
         m_run[k] = 0;
      end else if (nlow == 0) begin
         m_run[k] = 0;
      end else begin
         if (m_run[k] > 0 && m_in == m_last[k]) m_run[k]++;
         else m_run[k] = 1;
         if (m_run[k] == st) lat = 1'b1;
      end
      m_last[k] = m_in;
      if (lat) begin
         slot = 0;
         for (int i = 0; i < 8; i++) if (!an_s[i]) slot = i;
         val = -1;
         for (int v = 0; v < 16; v++) if (pat[v] == seg_s) val = v;
         if (val >= 0) begin
            m_digits[k][slot*4 +: 4] = val[3:0];
            m_valid[k][slot] = 1'b1;
         end else begin
            m_valid[k][slot] = 1'b0;
            ev = 1'b1;
         end
         m_dpo[k][slot]  = ~dp_s;
         m_seen[k][slot] = 1'b1;
         if (m_seen[k] == 8'hFF) begin
            m_done[k] = 1'b1;
            m_seen[k] = '0;
         end
      end
      if (ev) begin
         m_err[k] = 1'b1;
         if (m_cnt[k] < 255) m_cnt[k]++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      m_in = {an, seg, dp};
      #1;
      check_eq("s1 outputs", pack(d1_digits, d1_dig_valid, d1_dp_out, d1_frame_done, d1_err,
                                  d1_err_cnt),
               pack(m_digits[0], m_valid[0], m_dpo[0], m_done[0], m_err[0], 8'(m_cnt[0])));
      check_eq("s3 outputs", pack(d3_digits, d3_dig_valid, d3_dp_out, d3_frame_done, d3_err,
                                  d3_err_cnt),
               pack(m_digits[1], m_valid[1], m_dpo[1], m_done[1], m_err[1], 8'(m_cnt[1])));
      if (d1_frame_done) fd1++;
      if (d3_frame_done) fd3++;
   endtask

   task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
      an  = a;
      seg = s;
      dp  = d;
      repeat (n) tick();
   endtask

   // Asynchronous reset between clock edges; outputs must clear without a clock.
   task automatic async_reset();
      #2 sys_rst_n = 1'b0;
      #1;
      check_eq("async rst s1", pack(d1_digits, d1_dig_valid, d1_dp_out, d1_frame_done, d1_err,
                                    d1_err_cnt), 64'h0);
      check_eq("async rst s3", pack(d3_digits, d3_dig_valid, d3_dp_out, d3_frame_done, d3_err,
                                    d3_err_cnt), 64'h0);
      model_reset();
      #3 sys_rst_n = 1'b1;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      fd1       = 0;
      fd3       = 0;
      an        = 8'hFF;
      seg       = 7'h7F;
      dp        = 1'b1;
      sys_rst_n = 1'b0;
      model_reset();
      #3;
      check_eq("reset s1", pack(d1_digits, d1_dig_valid, d1_dp_out, d1_frame_done, d1_err,
                                d1_err_cnt), 64'h0);
      check_eq("reset s3", pack(d3_digits, d3_dig_valid, d3_dp_out, d3_frame_done, d3_err,
                                d3_err_cnt), 64'h0);
      @(negedge clk);
      sys_rst_n = 1'b1;

      // Rotating anodes, one clock each, all showing 0.
      for (int i = 0; i < 8; i++) drive(~(8'd1 << i), pat[0], 1'b1, 1);
      drive(8'hFF, 7'h7F, 1'b1, 3);
      check_eq("rotate digits", 64'(d1_digits), 64'h0);
      check_eq("rotate valid", 64'(d1_dig_valid), 64'hFF);
      check_eq("rotate err", 64'(d1_err), 64'h0);
      check_eq("rotate frame pulses", 64'(fd1), 64'd1);

      // Digits 1..8 on slots 0..7, DP lit on slot 3.
      for (int i = 0; i < 8; i++) drive(~(8'd1 << i), pat[i+1], (i == 3) ? 1'b0 : 1'b1, 3);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("s1 digits 87654321", 64'(d1_digits), 64'h8765_4321);
      check_eq("s1 dp_out", 64'(d1_dp_out), 64'h08);
      check_eq("s3 digits 87654321", 64'(d3_digits), 64'h8765_4321);
      check_eq("s3 dp_out", 64'(d3_dp_out), 64'h08);

      // Short hold on slot 2, full hold on slot 3.
      async_reset();
      drive(8'hFB, pat[5], 1'b1, 2);
      drive(8'hF7, pat[5], 1'b1, 3);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("s3 slot2 unlatched", 64'(d3_dig_valid), 64'h08);
      check_eq("s3 digits", 64'(d3_digits), 64'h0000_5000);

      // Two anodes low for two cycles.
      drive(8'hFC, pat[7], 1'b1, 2);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("multi err", 64'(d1_err), 64'h1);
      check_eq("multi err_cnt", 64'(d1_err_cnt), 64'd2);
      check_eq("multi digits kept", 64'(d1_digits), 64'h0000_5500);

      // Blank pattern on slot 5, then fill the remaining slots.
      fd1 = 0;
      fd3 = 0;
      drive(8'hDF, 7'h7F, 1'b1, 3);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("blank valid", 64'(d1_dig_valid), 64'h0C);
      check_eq("blank err_cnt s1", 64'(d1_err_cnt), 64'd3);
      check_eq("blank err_cnt s3", 64'(d3_err_cnt), 64'd3);
      drive(8'hFE, pat[9], 1'b1, 3);
      drive(8'hFD, pat[10], 1'b1, 3);
      drive(8'hEF, pat[11], 1'b1, 3);
      drive(8'hBF, pat[12], 1'b1, 3);
      drive(8'h7F, pat[13], 1'b1, 3);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("blank slot frame s1", 64'(fd1), 64'd1);
      check_eq("blank slot frame s3", 64'(fd3), 64'd0);

      // Error counter saturation.
      drive(8'h00, pat[1], 1'b1, 300);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("sat err_cnt s1", 64'(d1_err_cnt), 64'd255);
      check_eq("sat err_cnt s3", 64'(d3_err_cnt), 64'd255);

      // Randomized bus traffic.
      for (int it = 0; it < 200; it++) begin
         int         r, x, y;
         logic [7:0] a;
         logic [6:0] s;
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            a = 8'hFF;
         end else if (r == 1) begin
            x = int'($urandom_range(0, 7));
            y = (x + int'($urandom_range(1, 7))) % 8;
            a = ~((8'd1 << x) | (8'd1 << y));
         end else begin
            a = ~(8'd1 << $urandom_range(0, 7));
         end
         if ($urandom_range(0, 3) == 0) s = 7'($urandom);
         else s = pat[$urandom_range(0, 15)];
         drive(a, s, 1'($urandom), int'($urandom_range(1, 4)));
      end

      // Reset mid-frame discards partial progress.
      for (int i = 0; i < 4; i++) drive(~(8'd1 << i), pat[i], 1'b1, 3);
      async_reset();
      fd1 = 0;
      fd3 = 0;
      for (int i = 0; i < 7; i++) drive(~(8'd1 << i), pat[i+2], 1'b1, 3);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("post-rst 7 slots s1", 64'(fd1), 64'd0);
      check_eq("post-rst 7 slots s3", 64'(fd3), 64'd0);
      drive(8'h7F, pat[15], 1'b1, 3);
      drive(8'hFF, 7'h7F, 1'b1, 2);
      check_eq("post-rst 8 slots s1", 64'(fd1), 64'd1);
      check_eq("post-rst 8 slots s3", 64'(fd3), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
